// File: rtl/spi_slave_fifo.sv
// SPI slave with oversampled SPI inputs, an RX FIFO with a valid/ready handshake
// and a TX holding register. All logic runs on clk_sys.
module spi_slave_fifo #(
  parameter int DATA_W      = 8,
  parameter int CPOL        = 0,
  parameter int CPHA        = 0,
  parameter int MSB_FIRST   = 1,
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk_sys,
  input  logic              rst_n,
  input  logic              spi_clk,
  input  logic              spi_cs_n,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              rx_overrun,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              tx_underrun,
  output logic              busy
);
  localparam int   BW  = $clog2(DATA_W);
  localparam int   AW  = $clog2(FIFO_DEPTH);
  localparam logic POL = (CPOL != 0);

  typedef enum logic {IDLE, ACTIVE} state_t;

  logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
  logic                   sclk_prev_q, cs_prev_q;
  state_t                 state_q, state_d;
  logic [BW-1:0]          bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0]      rx_sh_q, rx_sh_d, tx_sh_q, tx_sh_d, hold_q, hold_d;
  logic                   hold_full_q, hold_full_d, push_q, push_d;
  logic                   miso_q, miso_d, ovr_q, ovr_d, und_q, und_d;
  logic [DATA_W-1:0]      mem_q [FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr_q, rd_ptr_q;
  logic [AW:0]            cnt_q, cnt_d;

  logic sclk_s, cs_s, mosi_s, lead_edge, trail_edge, sample_edge, shift_edge;
  logic cs_fall, cs_rise, load, pop, full, accept;

  assign sclk_s      = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s        = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s      = mosi_sync_q[SYNC_STAGES-1];
  assign lead_edge   = (sclk_prev_q == POL) && (sclk_s != POL);
  assign trail_edge  = (sclk_prev_q != POL) && (sclk_s == POL);
  assign sample_edge = (CPHA != 0) ? trail_edge : lead_edge;
  assign shift_edge  = (CPHA != 0) ? lead_edge : trail_edge;
  assign cs_fall     = cs_prev_q && !cs_s;
  assign cs_rise     = !cs_prev_q && cs_s;

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    rx_sh_d     = rx_sh_q;
    tx_sh_d     = tx_sh_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    push_d      = 1'b0;
    und_d       = 1'b0;
    load        = 1'b0;
    case (state_q)
      IDLE: if (cs_fall) begin
        state_d = ACTIVE;
        load    = (CPHA == 0);
      end
      ACTIVE: if (cs_rise) begin
        state_d   = IDLE;
        bit_cnt_d = '0;
        rx_sh_d   = '0;
        tx_sh_d   = '0;
      end else begin
        if (sample_edge) begin
          rx_sh_d = (MSB_FIRST != 0) ? {rx_sh_q[DATA_W-2:0], mosi_s}
                                     : {mosi_s, rx_sh_q[DATA_W-1:1]};
          if (bit_cnt_q == BW'(DATA_W-1)) begin
            bit_cnt_d = '0;
            push_d    = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + BW'(1);
          end
        end
        // A shift edge with bit_cnt at zero is the start of a new word.
        if (shift_edge) begin
          if (bit_cnt_q == '0) load = 1'b1;
          else tx_sh_d = (MSB_FIRST != 0) ? {tx_sh_q[DATA_W-2:0], 1'b0}
                                          : {1'b0, tx_sh_q[DATA_W-1:1]};
        end
      end
      default: state_d = IDLE;
    endcase
    if (load) begin
      tx_sh_d     = hold_full_q ? hold_q : '0;
      und_d       = !hold_full_q;
      hold_full_d = 1'b0;
    end
    // A handshake coinciding with a load refills the register for the next word.
    if (tx_valid && !hold_full_q) begin
      hold_d      = tx_data;
      hold_full_d = 1'b1;
    end
    miso_d = (state_d == ACTIVE) &&
             ((MSB_FIRST != 0) ? tx_sh_d[DATA_W-1] : tx_sh_d[0]);
  end

  assign pop    = (cnt_q != '0) && rx_ready;
  assign full   = (cnt_q == (AW+1)'(FIFO_DEPTH));
  assign accept = push_q && (!full || pop);
  assign ovr_d  = push_q && full && !pop;
  assign cnt_d  = cnt_q + {{AW{1'b0}}, accept} - {{AW{1'b0}}, pop};

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '0;
      mosi_sync_q <= '0;
      sclk_prev_q <= 1'b0;
      cs_prev_q   <= 1'b0;
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      rx_sh_q     <= '0;
      tx_sh_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      push_q      <= 1'b0;
      miso_q      <= 1'b0;
      ovr_q       <= 1'b0;
      und_q       <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_clk};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
      sclk_prev_q <= sclk_s;
      cs_prev_q   <= cs_s;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_sh_q     <= rx_sh_d;
      tx_sh_q     <= tx_sh_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      push_q      <= push_d;
      miso_q      <= miso_d;
      ovr_q       <= ovr_d;
      und_q       <= und_d;
      cnt_q       <= cnt_d;
      if (accept) begin
        mem_q[wr_ptr_q] <= rx_sh_q;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
    end
  end

  assign spi_miso    = miso_q;
  assign rx_data     = mem_q[rd_ptr_q];
  assign rx_valid    = (cnt_q != '0);
  assign rx_overrun  = ovr_q;
  assign tx_ready    = !hold_full_q;
  assign tx_underrun = und_q;
  assign busy        = (state_q == ACTIVE);
endmodule

// File: tb/tb_spi_slave_fifo.sv
// Bench for spi_slave_fifo: instance 0 is mode 0 MSB-first, instance 1 is
// CPOL=1/CPHA=1 LSB-first. Received words are scoreboarded per instance.
module tb_spi_slave_fifo;
  localparam int HALF = 8;

  logic            clk_sys = 1'b0;
  logic            rst_n;
  logic [1:0]      sck, csn, mosi, miso, rxv, rxr, ovr, txv, txr, und, busy;
  logic [1:0][7:0] rxd, txd;

  logic [7:0] mw [8];
  logic [7:0] sw [8];
  logic [7:0] exp0 [$];
  logic [7:0] exp1 [$];
  int n_chk = 0, n_err = 0;
  int ovr_n0 = 0, und_n1 = 0;

  always #5 clk_sys = ~clk_sys;

  spi_slave_fifo u0 (
    .clk_sys(clk_sys), .rst_n(rst_n), .spi_clk(sck[0]), .spi_cs_n(csn[0]),
    .spi_mosi(mosi[0]), .spi_miso(miso[0]), .rx_data(rxd[0]), .rx_valid(rxv[0]),
    .rx_ready(rxr[0]), .rx_overrun(ovr[0]), .tx_data(txd[0]), .tx_valid(txv[0]),
    .tx_ready(txr[0]), .tx_underrun(und[0]), .busy(busy[0]));

  spi_slave_fifo #(.CPOL(1), .CPHA(1), .MSB_FIRST(0)) u1 (
    .clk_sys(clk_sys), .rst_n(rst_n), .spi_clk(sck[1]), .spi_cs_n(csn[1]),
    .spi_mosi(mosi[1]), .spi_miso(miso[1]), .rx_data(rxd[1]), .rx_valid(rxv[1]),
    .rx_ready(rxr[1]), .rx_overrun(ovr[1]), .tx_data(txd[1]), .tx_valid(txv[1]),
    .tx_ready(txr[1]), .tx_underrun(und[1]), .busy(busy[1]));

  always @(negedge clk_sys) begin
    if (ovr[0]) ovr_n0++;
    if (und[1]) und_n1++;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [7:0] exp_pop(input int d);
    logic [7:0] v;
    v = 8'hxx;
    if (d == 0 && exp0.size() != 0) v = exp0.pop_front();
    if (d == 1 && exp1.size() != 0) v = exp1.pop_front();
    return v;
  endfunction

  task automatic push_tx(input int d, input logic [7:0] v);
    int t = 0;
    while (!txr[d] && t < 300) begin @(negedge clk_sys); t++; end
    chk("tx_ready_wait", txr[d], 1'b1);
    txd[d] = v;
    txv[d] = 1'b1;
    @(negedge clk_sys);
    txv[d] = 1'b0;
  endtask

  // SPI master; instance 1 uses CPOL=1, CPHA=1, LSB-first.
  task automatic frame(input int d, input int nbits, input bit pop_last);
    logic cpol;
    int   w, bi;
    cpol   = (d == 1);
    csn[d] = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      w  = i / 8;
      bi = cpol ? i % 8 : 7 - i % 8;
      if (!cpol) begin
        mosi[d] = mw[w][bi];
        repeat (HALF) @(negedge clk_sys);
        sck[d]    = ~cpol;
        sw[w][bi] = miso[d];
        if (pop_last && i == nbits - 1) begin
          // The push lands SYNC_STAGES+2 cycles after this edge; pop in that cycle.
          repeat (3) @(negedge clk_sys);
          chk("t7_head_vld", rxv[d], 1'b1);
          chk("t7_head", rxd[d], exp_pop(d));
          rxr[d] = 1'b1;
          @(negedge clk_sys);
          rxr[d] = 1'b0;
          repeat (HALF - 4) @(negedge clk_sys);
        end else begin
          repeat (HALF) @(negedge clk_sys);
        end
        sck[d] = cpol;
      end else begin
        repeat (HALF) @(negedge clk_sys);
        sck[d]  = ~cpol;
        mosi[d] = mw[w][bi];
        repeat (HALF) @(negedge clk_sys);
        sck[d]    = cpol;
        sw[w][bi] = miso[d];
      end
    end
    repeat (HALF) @(negedge clk_sys);
    csn[d] = 1'b1;
    repeat (2 * HALF) @(negedge clk_sys);
  endtask

  task automatic drain(input int d, input int n, input string tag);
    int t;
    for (int k = 0; k < n; k++) begin
      t = 0;
      while (!rxv[d] && t < 300) begin @(negedge clk_sys); t++; end
      chk({tag, "_vld"}, rxv[d], 1'b1);
      chk({tag, "_data"}, rxd[d], exp_pop(d));
      rxr[d] = 1'b1;
      @(negedge clk_sys);
      rxr[d] = 1'b0;
    end
    @(negedge clk_sys);
    chk({tag, "_empty"}, rxv[d], 1'b0);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_miso"}, miso[0], 1'b0);
    chk({tag, "_rxv"},  rxv[0],  1'b0);
    chk({tag, "_rxd"},  rxd[0],  8'h00);
    chk({tag, "_ovr"},  ovr[0],  1'b0);
    chk({tag, "_und"},  und[0],  1'b0);
    chk({tag, "_busy"}, busy[0], 1'b0);
    chk({tag, "_txr"},  txr[0],  1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int o, u;
    rst_n = 1'b0;
    sck = 2'b10; csn = 2'b11; mosi = '0; rxr = '0; txv = '0; txd = '0;
    repeat (3) @(negedge clk_sys);
    chk_reset("rst");
    chk("rst_txr1", txr[1], 1'b1);
    rst_n = 1'b1;
    repeat (3) @(negedge clk_sys);

    // Mode 0 single word, full duplex
    push_tx(0, 8'h3C);
    mw[0] = 8'hA5; exp0.push_back(8'hA5);
    frame(0, 8, 1'b0);
    chk("t1_miso", sw[0], 8'h3C);
    chk("t1_rxv", rxv[0], 1'b1);
    drain(0, 1, "t1");

    // Five words into a depth-4 FIFO
    o = ovr_n0;
    for (int k = 0; k < 5; k++) mw[k] = 8'(k + 1);
    for (int k = 0; k < 4; k++) exp0.push_back(8'(k + 1));
    frame(0, 40, 1'b0);
    chk("t2_ovr", ovr_n0 - o, 1);
    drain(0, 4, "t2");

    // Abort after 5 bits; hold word written during the aborted frame is sent next
    mw[0] = 8'hFF;
    fork
      frame(0, 5, 1'b0);
      begin repeat (12) @(negedge clk_sys); push_tx(0, 8'h99); end
    join
    chk("t3_nopush", rxv[0], 1'b0);
    mw[0] = 8'h81; exp0.push_back(8'h81);
    frame(0, 8, 1'b0);
    chk("t3_miso", sw[0], 8'h99);
    drain(0, 1, "t3");

    // CPOL=1 CPHA=1 LSB-first
    push_tx(1, 8'hC3);
    mw[0] = 8'h5A; exp1.push_back(8'h5A);
    frame(1, 8, 1'b0);
    chk("t4_miso", sw[0], 8'hC3);
    drain(1, 1, "t4");

    // No TX data: zeros out, one underrun per word
    u = und_n1;
    mw[0] = 8'h11; mw[1] = 8'h22; mw[2] = 8'h33;
    for (int k = 0; k < 3; k++) exp1.push_back(mw[k]);
    frame(1, 24, 1'b0);
    for (int k = 0; k < 3; k++) chk($sformatf("t5_miso%0d", k), sw[k], 8'h00);
    chk("t5_und", und_n1 - u, 3);
    drain(1, 3, "t5");

    // Reset mid-frame with a stored word and a full holding register
    mw[0] = 8'h42;
    frame(0, 8, 1'b0);
    chk("t6_pre_rxv", rxv[0], 1'b1);
    mw[0] = 8'hFF;
    fork
      frame(0, 8, 1'b0);
      begin
        repeat (6) @(negedge clk_sys);
        push_tx(0, 8'h55);
        repeat (60) @(negedge clk_sys);
        chk("t6_pre_txr", txr[0], 1'b0);
        chk("t6_pre_busy", busy[0], 1'b1);
        rst_n = 1'b0;
        #1;
        chk_reset("t6_rst");
        repeat (3) @(negedge clk_sys);
        rst_n = 1'b1;
      end
    join
    exp0.delete();
    chk("t6_idle", busy[0], 1'b0);
    chk("t6_rxv", rxv[0], 1'b0);
    mw[0] = 8'h7E; exp0.push_back(8'h7E);
    frame(0, 8, 1'b0);
    drain(0, 1, "t6");

    // Full FIFO: pop and push in the same cycle
    for (int k = 0; k < 4; k++) begin mw[k] = 8'(8'h11 + k); exp0.push_back(mw[k]); end
    frame(0, 32, 1'b0);
    o = ovr_n0;
    mw[0] = 8'h15;
    frame(0, 8, 1'b1);
    exp0.push_back(8'h15);
    chk("t7_ovr", ovr_n0 - o, 0);
    drain(0, 4, "t7");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
